// File: rtl/id_regfile_sb.sv
// 32x32 GPR file with per-register in-flight write counters for decode hazard checks.
// Optional macro RF_BYPASS_EN: forward the same-cycle WB write onto the read ports.
module id_regfile_sb #(
  parameter int          CNT_W     = 2,
  parameter logic [31:0] RESET_VAL = 32'h0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [37:0] ws_to_rf_bus,
  input  logic        ds_issue_valid,
  input  logic        ds_issue_we,
  input  logic [4:0]  ds_issue_dest,
  input  logic        flush,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2,
  output logic        rbusy1,
  output logic        rbusy2,
  output logic        issue_stall,
  output logic        sb_err
);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  assign {rf_we, rf_waddr, rf_wdata} = ws_to_rf_bus;

  logic [31:0]      regs_reg [32];
  logic [CNT_W-1:0] cnt_reg  [32];
  logic [CNT_W-1:0] cnt_next [32];
  logic             sb_err_reg;
  logic             sb_err_next;

  logic        issue;
  logic        retire;
  logic [31:0] inc_vec;
  logic [31:0] dec_vec;

  assign issue  = ds_issue_valid && ds_issue_we && (ds_issue_dest != 5'd0);
  assign retire = rf_we && (rf_waddr != 5'd0);

  // Entry 0 never sees inc/dec because issue and retire both exclude r0.
  generate
    for (genvar gi = 0; gi < 32; gi++) begin : g_sel
      assign inc_vec[gi] = issue  && (ds_issue_dest == 5'(gi));
      assign dec_vec[gi] = retire && (rf_waddr == 5'(gi));
    end
  endgenerate

  always_comb begin
    cnt_next    = cnt_reg;
    sb_err_next = sb_err_reg;
    for (int i = 0; i < 32; i++) begin
      if (flush) begin
        cnt_next[i] = '0;
      end else if (inc_vec[i] && !dec_vec[i]) begin
        if (cnt_reg[i] == CNT_MAX) sb_err_next = 1'b1;
        else                       cnt_next[i] = cnt_reg[i] + 1'b1;
      end else if (dec_vec[i] && !inc_vec[i]) begin
        if (cnt_reg[i] == '0) sb_err_next = 1'b1;
        else                  cnt_next[i] = cnt_reg[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < 32; i++) begin
        regs_reg[i] <= (i == 0) ? 32'h0 : RESET_VAL;
        cnt_reg[i]  <= '0;
      end
      sb_err_reg <= 1'b0;
    end else begin
      if (retire) regs_reg[rf_waddr] <= rf_wdata;
      cnt_reg    <= cnt_next;
      sb_err_reg <= sb_err_next;
    end
  end

  logic [1:0][4:0]  raddr_v;
  logic [1:0][31:0] rdata_v;
  logic [1:0]       rbusy_v;
  assign raddr_v[0] = raddr1;
  assign raddr_v[1] = raddr2;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rd
      always_comb begin
        rdata_v[gi] = (raddr_v[gi] == 5'd0) ? 32'h0 : regs_reg[raddr_v[gi]];
        rbusy_v[gi] = (cnt_reg[raddr_v[gi]] != '0);
`ifdef RF_BYPASS_EN
        // The retiring write is already visible, so only older reservations keep it busy.
        if (rf_we && (rf_waddr == raddr_v[gi]) && (raddr_v[gi] != 5'd0)) begin
          rdata_v[gi] = rf_wdata;
          rbusy_v[gi] = (cnt_reg[raddr_v[gi]] > CNT_W'(1));
        end
`endif
      end
    end
  endgenerate

  assign rdata1      = rdata_v[0];
  assign rdata2      = rdata_v[1];
  assign rbusy1      = rbusy_v[0];
  assign rbusy2      = rbusy_v[1];
  assign issue_stall = ds_issue_we && (ds_issue_dest != 5'd0) && (cnt_reg[ds_issue_dest] == CNT_MAX);
  assign sb_err      = sb_err_reg;
endmodule

// File: tb/tb_id_regfile_sb.sv
// Bench for id_regfile_sb: directed scenarios then random traffic against a counter/array model.
module tb_id_regfile_sb;
  localparam int CNT_W = 2;
  localparam int MAX   = (1 << CNT_W) - 1;

  logic        clk = 1'b0;
  logic        resetn;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [37:0] ws_to_rf_bus;
  logic        ds_issue_valid, ds_issue_we, flush;
  logic [4:0]  ds_issue_dest, raddr1, raddr2;
  logic [31:0] rdata1, rdata2;
  logic        rbusy1, rbusy2, issue_stall, sb_err;

  assign ws_to_rf_bus = {we, waddr, wdata};
  always #5 clk = ~clk;

  id_regfile_sb #(.CNT_W(CNT_W), .RESET_VAL(32'h0)) dut (
    .clk(clk), .resetn(resetn), .ws_to_rf_bus(ws_to_rf_bus),
    .ds_issue_valid(ds_issue_valid), .ds_issue_we(ds_issue_we), .ds_issue_dest(ds_issue_dest),
    .flush(flush), .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
    .rbusy1(rbusy1), .rbusy2(rbusy2), .issue_stall(issue_stall), .sb_err(sb_err)
  );

  logic [31:0] m_regs [32];
  int          m_cnt  [32];
  bit          m_err;
  int          n_assert = 0;
  int          n_fail   = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_rdata(logic [4:0] a);
    if (a == 0) return 32'h0;
`ifdef RF_BYPASS_EN
    if (we && waddr == a) return wdata;
`endif
    return m_regs[a];
  endfunction

  function automatic logic exp_busy(logic [4:0] a);
    if (a == 0) return 1'b0;
`ifdef RF_BYPASS_EN
    if (we && waddr == a) return m_cnt[a] > 1;
`endif
    return m_cnt[a] != 0;
  endfunction

  task automatic model_update();
    bit iss, ret;
    if (!resetn) begin
      for (int i = 0; i < 32; i++) begin m_regs[i] = 32'h0; m_cnt[i] = 0; end
      m_err = 1'b0;
      return;
    end
    iss = ds_issue_valid && ds_issue_we && ds_issue_dest != 0;
    ret = we && waddr != 0;
    if (ret) m_regs[waddr] = wdata;
    if (flush) begin
      for (int i = 0; i < 32; i++) m_cnt[i] = 0;
    end else if (!(iss && ret && ds_issue_dest == waddr)) begin
      if (iss) begin
        if (m_cnt[ds_issue_dest] == MAX) m_err = 1'b1;
        else m_cnt[ds_issue_dest]++;
      end
      if (ret) begin
        if (m_cnt[waddr] == 0) m_err = 1'b1;
        else m_cnt[waddr]--;
      end
    end
  endtask

  // Inputs are already applied; check mid-cycle, then advance model at the edge.
  task automatic cycle(string tag);
    @(negedge clk);
    if (resetn) begin
      chk($sformatf("%s.rdata1", tag), rdata1, exp_rdata(raddr1));
      chk($sformatf("%s.rdata2", tag), rdata2, exp_rdata(raddr2));
      chk($sformatf("%s.rbusy1", tag), 32'(rbusy1), 32'(exp_busy(raddr1)));
      chk($sformatf("%s.rbusy2", tag), 32'(rbusy2), 32'(exp_busy(raddr2)));
      chk($sformatf("%s.stall", tag), 32'(issue_stall),
          32'(ds_issue_we && ds_issue_dest != 0 && m_cnt[ds_issue_dest] == MAX));
      chk($sformatf("%s.sb_err", tag), 32'(sb_err), 32'(m_err));
    end
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    we = 1'b0; waddr = 5'd0; wdata = 32'h0;
    ds_issue_valid = 1'b0; ds_issue_we = 1'b0; ds_issue_dest = 5'd0; flush = 1'b0;
  endtask

  task automatic issue_to(logic [4:0] d);
    ds_issue_valid = 1'b1; ds_issue_we = 1'b1; ds_issue_dest = d;
  endtask

  task automatic do_reset();
    idle(); resetn = 1'b0;
    cycle("rst"); cycle("rst");
    resetn = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin m_regs[i] = 32'hX; m_cnt[i] = 0; end
    m_err = 1'b0;
    raddr1 = 5'd0; raddr2 = 5'd0;
    do_reset();

    // reset state of every register
    raddr1 = 5'd5; raddr2 = 5'd0;
    cycle("reset_r5");
    chk("reset_rdata1", rdata1, 32'h0);
    for (int i = 1; i < 32; i += 2) begin
      raddr1 = 5'(i); raddr2 = 5'(i + 1);
      cycle("reset_all");
    end

    // write then read, same cycle and next cycle
    we = 1'b1; waddr = 5'd3; wdata = 32'hDEADBEEF; raddr1 = 5'd3; raddr2 = 5'd3;
    cycle("wr_same");
    idle();
    cycle("wr_next");
    chk("wr_next_val", rdata1, 32'hDEADBEEF);

    // r0 is never written nor reserved
    we = 1'b1; waddr = 5'd0; wdata = 32'h1234; issue_to(5'd0); raddr1 = 5'd0; raddr2 = 5'd0;
    cycle("r0_wr");
    idle();
    cycle("r0_after");
    chk("r0_rdata", rdata1, 32'h0);

    // fill r7 to saturation, force one more issue, then drain
    raddr1 = 5'd7; raddr2 = 5'd3;
    for (int i = 0; i < 3; i++) begin issue_to(5'd7); cycle("sat_issue"); end
    cycle("sat_forced");
    idle();
    cycle("sat_err");
    chk("sat_err_set", 32'(sb_err), 32'h1);
    for (int i = 0; i < 3; i++) begin
      we = 1'b1; waddr = 5'd7; wdata = $urandom; cycle("sat_retire");
    end
    idle();
    cycle("sat_drained");
    chk("sat_rbusy_clear", 32'(rbusy1), 32'h0);

    // simultaneous reserve and retire on the same register
    do_reset();
    raddr1 = 5'd9; raddr2 = 5'd4;
    issue_to(5'd9); cycle("sim_pre");
    issue_to(5'd9); we = 1'b1; waddr = 5'd9; wdata = 32'hA5A5_0F0F;
    cycle("sim_both");
    idle();
    cycle("sim_after");
    chk("sim_rbusy", 32'(rbusy1), 32'h1);
    chk("sim_rdata", rdata1, 32'hA5A5_0F0F);

    // flush clears reservations while the write still lands
    issue_to(5'd4); cycle("fl_pre");
    issue_to(5'd4); cycle("fl_pre");
    issue_to(5'd8); cycle("fl_pre");
    idle(); raddr1 = 5'd4; raddr2 = 5'd8;
    flush = 1'b1; we = 1'b1; waddr = 5'd4; wdata = 32'h55;
    cycle("flush");
    idle();
    cycle("fl_after");
    chk("fl_rdata", rdata1, 32'h55);
    chk("fl_rbusy8", 32'(rbusy2), 32'h0);

    // random traffic on a small register window to hit saturation and bypass
    do_reset();
    for (int n = 0; n < 400; n++) begin
      resetn         = ($urandom_range(0, 63) != 0);
      we             = 1'($urandom_range(0, 1));
      waddr          = 5'($urandom_range(0, 7));
      wdata          = $urandom;
      ds_issue_valid = 1'($urandom_range(0, 1));
      ds_issue_we    = ($urandom_range(0, 3) != 0);
      ds_issue_dest  = 5'($urandom_range(0, 7));
      flush          = ($urandom_range(0, 15) == 0);
      raddr1         = $urandom_range(0, 1) ? waddr : 5'($urandom_range(0, 31));
      raddr2         = 5'($urandom_range(0, 7));
      cycle("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
